instr_fetch_unit: RTL and testbench

//  Fetch stage of the MIPS monocycle core; sits directly upstream of the control decoder.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/next_pc_sel.sv | 31 +++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, opcode constants, PC step and branch offset helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Sign-extended word offset of a branch immediate, expressed in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump, then taken branch, then sequential pc+4.
// Latency: purely combinational.
// Backpressure: none; the value is sampled by the fetch unit on exec_done.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        xor_bne,
  input  logic        jump,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic take_branch;

  // xor_bne flips the zero test so BEQ and BNE share one comparator.
  assign take_branch = branch & (alu_zero ^ xor_bne);

  // Jump outranks branch because the decoder raises branch alongside jump on J.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC, fetches one instruction, holds it until the datapath reports completion.
// Latency: >=2 cycles per instruction (fetch with same-cycle rvalid, then exec with exec_done).
// Backpressure: waits in fetch for imem_rvalid and in exec for exec_done; strays in other states ignored.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             branch,
  input  logic             xor_bne,
  input  logic             jump,
  input  logic             alu_zero,
  input  logic             exec_done,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired_cnt
);

  // Low address bits are forced clear so pc stays word aligned whatever the parameter says.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      next_pc;

  assign pc_plus4 = pc_q + PC_STEP;

  next_pc_sel u_next_pc_sel (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .xor_bne  (xor_bne),
    .jump     (jump),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  // Next-state logic: capture on rvalid in fetch, advance PC and count on exec_done in exec.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight fetch or execution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc          = pc_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed instruction stream, per-cycle model compare.
// Latency: not applicable.
// Backpressure: drives delayed rvalid and stray handshakes.
module tb_instr_fetch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          branch = 1'b0;
  logic          xor_bne = 1'b0;
  logic          jump = 1'b0;
  logic          alu_zero = 1'b0;
  logic          exec_done = 1'b0;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] retired_cnt;

  int n_chk = 0;
  int n_fail = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .branch      (branch),
    .xor_bne     (xor_bne),
    .jump        (jump),
    .alu_zero    (alu_zero),
    .exec_done   (exec_done),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: where the unit is in the instruction cycle, the PC, held word, count.
  int            m_phase = 0;   // 0 = dead cycle after reset, 1 = waiting for memory, 2 = executing
  logic [31:0]   m_pc = '0;
  logic [31:0]   m_instr = '0;
  int unsigned   m_cnt = 0;

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] w,
                                         input logic j, input logic b, input logic xb, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(w[15:0])) * 4;
    if (j)                return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
    else if (b && (z != xb)) return seq + 32'(off);
    else                  return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_rvalid) begin m_instr = imem_rdata; m_phase = 2; end
    end else if (exec_done) begin
      m_pc = target(m_pc, m_instr, jump, branch, xor_bne, alu_zero);
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_phase = 1;
    end
  end

  // Compare the DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("imem_req",    32'(imem_req),    32'(m_phase == 1));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("pc",          pc,               m_pc);
      chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
      chk("instr",       instr,            m_instr);
      chk("retired_cnt", 32'(retired_cnt), m_cnt);
      if (m_phase == 2) chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
    end
  end

  // One instruction: wait for a request, optionally delay rvalid, then execute with the given decode.
  task automatic issue(input logic [31:0] w, input logic b, input logic xb, input logic j,
                       input logic z, input int dly, input bit stray);
    int t = 0;
    while (!imem_req && t < 20) begin @(negedge clk); t++; end
    if (!imem_req) chk("fetch_timeout", 32'(imem_req), 32'd1);
    for (int i = 0; i < dly; i++) begin
      imem_rvalid = 1'b0;
      exec_done   = stray && (i == 1);
      @(negedge clk);
    end
    exec_done   = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    if (stray) begin
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    branch = b; xor_bne = xb; jump = j; alu_zero = z;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    branch = 1'b0; xor_bne = 1'b0; jump = 1'b0; alu_zero = 1'b0;
  endtask

  function automatic logic [31:0] j_word(input logic [31:0] dest);
    return {6'b000010, dest[27:2]};
  endfunction

  initial begin
    int t;
    // 1: reset, LW with same-cycle rvalid
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req_c2", 32'(imem_req), 32'd1);
    chk("t1_valid_c2", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t1_valid_c3", 32'(instr_valid), 32'd1);
    chk("t1_opcode", 32'(opcode), 32'h23);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk("t1_pc", pc, 32'h4);
    chk("t1_cnt", 32'(retired_cnt), 32'd1);

    // 2: BEQ at 0x10 backwards, taken and not taken
    issue(j_word(32'h10), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t2_jump", pc, 32'h10);
    issue(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("t2_beq_taken", pc, 32'h0C);
    issue(j_word(32'h10), 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    issue(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("t2_beq_fall", pc, 32'h14);

    // 3: BNE at 0x20
    issue(j_word(32'h20), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    issue(32'h1400_0003, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("t3_bne_taken", pc, 32'h30);
    issue(j_word(32'h20), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    issue(32'h1400_0003, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk("t3_bne_fall", pc, 32'h24);

    // 4: J with branch and xor_bne also high
    issue(j_word(32'h1000), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_at_1000", pc, 32'h1000);
    issue(32'h0800_0040, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_jump_wins", pc, 32'h100);

    // 5: rvalid 5 cycles late, stray exec_done while waiting, stray rvalid while executing
    issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    chk("t5_pc", pc, 32'h104);
    chk("t5_cnt", 32'(retired_cnt), 32'd12);

    // PC wrap backwards below 0 and forwards past all-ones; counter wrap
    issue(j_word(32'h0), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    issue(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("wrap_neg", pc, 32'hFFFF_FFFC);
    issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("wrap_pos", pc, 32'h0);
    issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("cnt_wrap", 32'(retired_cnt), 32'd0);
    issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("cnt_after_wrap", 32'(retired_cnt), 32'd1);
    chk("pc_after_wrap", pc, 32'h8);

    // 6: reset in exec at pc=0x40
    issue(j_word(32'h40), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_pc40", pc, 32'h40);
    t = 0;
    while (!imem_req && t < 20) begin @(negedge clk); t++; end
    imem_rvalid = 1'b1; imem_rdata = 32'hAC22_0008;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t6_in_exec", 32'(instr_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_instr", instr, 32'h0);
    chk("t6_rst_cnt", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (!imem_req && t < 10) begin @(negedge clk); t++; end
    chk("t6_req_after", 32'(imem_req), 32'd1);
    chk("t6_addr_after", imem_addr, 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
